// File: rtl/tdm_pkg.sv
// Shared types for the TDM demultiplexer: channel ids, alternate-mode
// states and the mismatch counter width.
package tdm_pkg;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    typedef enum logic {
        EXPECT_A = 1'b0,
        EXPECT_B = 1'b1
    } alt_state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word reads as zero when empty.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/tdm_demux.sv
// Routes a time-multiplexed word stream into two buffered channels, either
// by in_sel or by an internal A/B alternation that counts sel mismatches.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alt_en,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] mismatch_cnt
);

    alt_state_e state;
    chan_e      target;
    logic       a_full;
    logic       a_empty;
    logic       b_full;
    logic       b_empty;
    logic       xfer;
    logic       mis;

    always_comb begin
        target = in_sel ? CH_B : CH_A;
        if (alt_en) target = (state == EXPECT_B) ? CH_B : CH_A;
    end

    assign in_ready = (target == CH_A) ? !a_full : !b_full;
    assign xfer     = in_valid && in_ready;
    assign mis      = alt_en && xfer && (in_sel != (state == EXPECT_B));
    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer && target == CH_A),
        .wdata (in_data),
        .pop   (a_ready),
        .rdata (a_data),
        .full  (a_full),
        .empty (a_empty)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer && target == CH_B),
        .wdata (in_data),
        .pop   (b_ready),
        .rdata (b_data),
        .full  (b_full),
        .empty (b_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EXPECT_A;
            mismatch_cnt <= '0;
        end else begin
            if (!alt_en)
                state <= EXPECT_A;
            else if (xfer)
                state <= (state == EXPECT_A) ? EXPECT_B : EXPECT_A;
            if (mis && mismatch_cnt != '1)
                mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: routing, backpressure, alternate mode,
// mismatch counting/saturation, full-FIFO push refusal and async reset.
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic       alt_en;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] mismatch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(8), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alt_en       (alt_en),
        .a_data       (a_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_data       (b_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .mismatch_cnt (mismatch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_sel = 0; in_valid = 0;
        alt_en = 0; a_ready = 0; b_ready = 0;
        #3;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_mis", mismatch_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // basic sel routing, both consumers ready
        a_ready = 1; b_ready = 1;
        drive(1, 0, 8'h11);
        tick();
        drive(1, 1, 8'h22);
        chk("a_lat1_valid", a_valid, 1);
        chk("a_lat1_data", a_data, 8'h11);
        tick();
        drive(0, 0, 8'h00);
        chk("b_lat1_valid", b_valid, 1);
        chk("b_lat1_data", b_data, 8'h22);
        chk("a_popped", a_valid, 0);
        tick();
        chk("b_popped", b_valid, 0);

        // backpressure on B, A still flows
        a_ready = 0; b_ready = 0;
        drive(1, 1, 8'h01);
        tick();
        drive(1, 1, 8'h02);
        tick();
        drive(1, 1, 8'h03);
        chk("b_full_in_ready", in_ready, 0);
        chk("b_hold_data", b_data, 8'h01);
        tick();
        chk("b_still_full", in_ready, 0);
        drive(1, 0, 8'h55);
        chk("a_ready_while_b_full", in_ready, 1);
        tick();
        drive(0, 0, 8'h00);
        chk("a_got_55", a_data, 8'h55);
        b_ready = 1;
        #1;
        chk("b_order0", b_data, 8'h01);
        tick();
        chk("b_order1", b_data, 8'h02);
        tick();
        chk("b_drained", b_valid, 0);
        a_ready = 1;
        tick();
        chk("a_drained", a_valid, 0);

        // alternate mode, matching sel
        alt_en = 1;
        drive(1, 0, 8'hA0);
        tick();
        drive(1, 1, 8'hA1);
        chk("alt_w0_a", a_data, 8'hA0);
        tick();
        drive(1, 0, 8'hA2);
        chk("alt_w1_b", b_data, 8'hA1);
        chk("alt_w1_a_empty", a_valid, 0);
        tick();
        drive(1, 1, 8'hA3);
        chk("alt_w2_a", a_data, 8'hA2);
        tick();
        drive(0, 0, 8'h00);
        chk("alt_w3_b", b_data, 8'hA3);
        chk("alt_mis0", mismatch_cnt, 0);

        // 300 words with sel=0: every other one mismatches
        drive(1, 0, 8'h00);
        for (int i = 0; i < 300; i++) tick();
        drive(0, 0, 8'h00);
        tick();
        chk("alt_mis150", mismatch_cnt, 150);
        tick();
        chk("mis_hold", mismatch_cnt, 150);
        drive(1, 0, 8'h00);
        for (int i = 0; i < 300; i++) tick();
        drive(0, 0, 8'h00);
        tick();
        chk("mis_sat", mismatch_cnt, 255);
        alt_en = 0;
        tick();
        tick();

        // full A: pop and refused push in the same cycle
        a_ready = 0; b_ready = 0;
        drive(1, 0, 8'h31);
        tick();
        drive(1, 0, 8'h32);
        tick();
        drive(1, 0, 8'h33);
        a_ready = 1;
        #1;
        chk("a_full_in_ready", in_ready, 0);
        tick();
        drive(0, 0, 8'h00);
        a_ready = 0;
        #1;
        chk("after_pop_valid", a_valid, 1);
        chk("after_pop_data", a_data, 8'h32);
        chk("after_pop_ready", in_ready, 1);
        a_ready = 1;
        tick();
        chk("occ_was_1", a_valid, 0);
        a_ready = 0;

        // async reset between edges with two words buffered
        drive(1, 0, 8'h41);
        tick();
        drive(1, 0, 8'h42);
        tick();
        drive(0, 0, 8'h00);
        chk("pre_rst_valid", a_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_a_valid", a_valid, 0);
        chk("async_a_data", a_data, 0);
        chk("async_mis", mismatch_cnt, 0);
        chk("async_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_a_valid", a_valid, 0);
        chk("rel_mis", mismatch_cnt, 0);
        drive(1, 0, 8'h77);
        tick();
        drive(0, 0, 8'h00);
        chk("rel_new_word", a_data, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, per-channel FIFO depth in words (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_data  input  WIDTH  time-multiplexed input word.
REQ-006 SHALL have port in_sel  input  1  channel select: 0 routes to channel A, 1 routes to channel B.
REQ-007 SHALL have port in_valid  input  1  in_data/in_sel are valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts the input word this cycle.
REQ-009 SHALL have port alt_en  input  1  alternate mode: routing follows an internal A/B toggle and ignores in_sel.
REQ-010 SHALL have ports a_data/b_data  output  WIDTH  channel A/B head word.
REQ-011 SHALL have ports a_valid/b_valid  output  1  channel A/B head word is valid.
REQ-012 SHALL have ports a_ready/b_ready  input  1  channel A/B consumer accepts the head word.
REQ-013 SHALL have port mismatch_cnt  output  8  count of alternate-mode transfers whose in_sel differed from the expected channel.

Function
REQ-014 Target channel SHALL be in_sel when alt_en=0, and the alternate-mode state (EXPECT_A yields A, EXPECT_B yields B) when alt_en=1.
REQ-015 in_ready SHALL be combinationally high iff the target channel FIFO holds fewer than DEPTH words; it SHALL NOT depend on in_valid.
REQ-016 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; the word is written to the target FIFO only.
REQ-017 A transferred word SHALL be visible on the target output, with valid asserted, on the first cycle after the transfer edge when that FIFO was empty (latency 1 cycle).
REQ-018 Each output SHALL pop on a rising edge with x_valid=1 and x_ready=1; x_data SHALL hold stable while x_valid=1 and x_ready=0.
REQ-019 Each channel SHALL preserve the arrival order of its words; channels are independent, and backpressure on one SHALL NOT block transfers to the other.
REQ-020 Simultaneous push and pop on a non-full FIFO SHALL leave its occupancy unchanged; a full FIFO SHALL NOT accept a push in the same cycle as a pop (no bypass).
REQ-021 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range from 0 to DEPTH inclusive.
REQ-022 The alternate state machine SHALL have two states, EXPECT_A and EXPECT_B; with alt_en=1 it SHALL toggle on every input transfer and hold otherwise.
REQ-023 When alt_en=0, the state SHALL go to EXPECT_A on the next edge.
REQ-024 When alt_en=1 and a transfer has in_sel not equal to the expected channel, mismatch_cnt SHALL increment by 1, saturating at 255; the word is still routed per the state.
REQ-025 mismatch_cnt SHALL never decrement except on reset.

Reset
REQ-026 On rst=1, both FIFOs SHALL empty immediately, regardless of the clock.
REQ-027 While rst=1: a_valid=0, b_valid=0, a_data=0, b_data=0, mismatch_cnt=0, and the state is EXPECT_A.
REQ-028 in_ready SHALL be 1 during and after reset, since both FIFOs are empty.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; no word SHALL appear on an output after reset release unless it was transferred after release.

Structure
REQ-030 Package tdm_pkg SHALL hold typedef chan_e {CH_A, CH_B}, typedef alt_state_e {EXPECT_A, EXPECT_B}, and constant CNT_W=8.
REQ-031 The per-channel buffer SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty interface), instantiated twice.
REQ-032 The top level SHALL contain only routing, the alternate state machine, and the mismatch counter.

Verification
REQ-033 Reset release, then alt_en=0; send 0x11 with sel=0 and 0x22 with sel=1, both readys high -> a_data=0x11 one cycle after its transfer, b_data=0x22 one cycle after its transfer.
REQ-034 b_ready=0; send 0x01, 0x02, 0x03 with sel=1 -> in_ready low after the 2nd transfer; a sel=0 word is still accepted; with b_ready=1, 0x01 then 0x02 are popped in order.
REQ-035 alt_en=1; send 4 words with in_sel=0,1,0,1 -> routed A,B,A,B; mismatch_cnt=0.
REQ-036 alt_en=1; send 300 words with in_sel=0 -> 150 mismatches counted; mismatch_cnt saturates at 255 only after 255 mismatches, so here it reads 150.
REQ-037 FIFO A full, then apply a_ready=1 and in_valid=1 (sel=0) in the same cycle -> pop occurs, push refused, occupancy 1.
REQ-038 Assert rst between clock edges while A holds 2 words -> a_valid drops immediately; after release a_valid=0 and mismatch_cnt=0.
